// File: rtl/serial_frame_tx_pkg.sv
// Shared definitions for the serial "1010" link: FSM state codes and the preamble,
// which the receive-side sequence detector keys on as well.
package serial_frame_tx_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_DATA = 2'd2,
    S_GAP  = 2'd3
  } state_e;

  localparam logic [3:0]  PREAMBLE_1010 = 4'b1010;
  localparam int unsigned PRE_LEN       = 4;

endpackage

// File: rtl/serial_frame_tx_piso_shift.sv
// Parallel-in serial-out shifter: loads a word, presents its MSB and shifts left on demand.
module piso_shift
  import serial_frame_tx_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             shift_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] shift_q;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      shift_q <= '0;
    end else if (load_i) begin
      shift_q <= data_i;
    end else if (shift_i) begin
      shift_q <= shift_q << 1;
    end
  end

  assign msb_o = shift_q[WIDTH-1];

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: preamble, MSB-first payload, then a forced zero gap,
// one registered bit per clock; a new word is accepted only while idle.
module serial_frame_tx
  import serial_frame_tx_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter logic [3:0]  PREAMBLE = PREAMBLE_1010,
  parameter int unsigned IDLE_GAP = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out,
  output logic             busy,
  output logic             last,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int unsigned BC_W = $clog2(WIDTH + PRE_LEN + IDLE_GAP + 1);

  state_e           state_q, state_d;
  logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic             out_q, out_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             accept;
  logic             piso_msb;

  assign accept = (state_q == S_IDLE) & ready_q & in_valid;

  piso_shift #(
    .WIDTH(WIDTH)
  ) u_piso (
    .clk    (clk),
    .reset_i(reset),
    .load_i (accept),
    .data_i (in_data),
    .shift_i(state_q == S_DATA),
    .msb_o  (piso_msb)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      out_q       <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      last_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      out_q       <= out_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      last_q      <= last_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // State/counter describe the bit to be registered onto out at the next edge.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d   = S_PRE;
          bit_cnt_d = BC_W'(PRE_LEN - 1);
        end
      end
      S_PRE: begin
        if (bit_cnt_q == '0) begin
          state_d   = S_DATA;
          bit_cnt_d = BC_W'(WIDTH - 1);
        end else begin
          bit_cnt_d = bit_cnt_q - BC_W'(1);
        end
      end
      S_DATA: begin
        if (bit_cnt_q == '0) begin
          state_d   = S_GAP;
          bit_cnt_d = BC_W'(IDLE_GAP - 1);
        end else begin
          bit_cnt_d = bit_cnt_q - BC_W'(1);
        end
      end
      S_GAP: begin
        if (bit_cnt_q == '0) begin
          state_d   = S_IDLE;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q - BC_W'(1);
        end
      end
      default: begin
        state_d   = S_IDLE;
        bit_cnt_d = '0;
      end
    endcase
  end

  // A frame counts at the end of the cycle in which its LSB is on out.
  always_comb begin
    out_d       = 1'b0;
    last_d      = 1'b0;
    ready_d     = ready_q;
    busy_d      = busy_q;
    frame_cnt_d = frame_cnt_q + CNT_W'(last_q);
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_PRE: out_d = PREAMBLE[bit_cnt_q[1:0]];
      S_DATA: begin
        out_d  = piso_msb;
        last_d = (bit_cnt_q == '0);
      end
      S_GAP: begin
        if (bit_cnt_q == '0) begin
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign out       = out_q;
  assign in_ready  = ready_q;
  assign busy      = busy_q;
  assign last      = last_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx against a queue-based frame model.
module tb_serial_frame_tx;

  localparam int unsigned W   = 8;
  localparam int unsigned G   = 2;
  localparam int unsigned CW  = 4;
  localparam int unsigned PRE = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          din_ready;
  logic          dout;
  logic          dbusy;
  logic          dlast;
  logic [CW-1:0] dframe_cnt;

  serial_frame_tx #(
    .WIDTH   (W),
    .PREAMBLE(4'b1010),
    .IDLE_GAP(G),
    .CNT_W   (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (din_ready),
    .out      (dout),
    .busy     (dbusy),
    .last     (dlast),
    .frame_cnt(dframe_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model: each accepted word becomes a queue of the bits the line must carry.
  bit            mq[$];
  int unsigned   mpos;
  logic          m_out, m_last, m_ready, m_prev_last, m_acc;
  logic [CW-1:0] m_cnt;
  logic [3:0]    pre_pat = 4'b1010;
  logic [31:0]   obs_v;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    m_acc = 1'b0;
    if (reset) begin
      mq.delete();
      m_ready = 1'b1; m_out = 1'b0; m_last = 1'b0;
      m_prev_last = 1'b0; m_cnt = '0; mpos = 0;
    end else begin
      if (m_prev_last) m_cnt = m_cnt + 1'b1;
      m_prev_last = 1'b0; m_out = 1'b0; m_last = 1'b0;
      if (m_ready && in_valid) begin
        for (int i = 3; i >= 0; i--) mq.push_back(pre_pat[i]);
        for (int i = W - 1; i >= 0; i--) mq.push_back(in_data[i]);
        repeat (G) mq.push_back(1'b0);
        m_ready = 1'b0; m_acc = 1'b1; mpos = 0;
      end else if (mq.size() != 0) begin
        m_out = mq.pop_front();
        m_last = (mpos == PRE + W - 1);
        m_prev_last = m_last;
        mpos++;
        if (mq.size() == 0) m_ready = 1'b1;
      end
    end
    #1;
    obs_v = {obs_v[30:0], dout};
    check("out", 32'(dout), 32'(m_out));
    check("in_ready", 32'(din_ready), 32'(m_ready));
    check("busy", 32'(dbusy), 32'(!m_ready));
    check("last", 32'(dlast), 32'(m_last));
    check("frame_cnt", 32'(dframe_cnt), 32'(m_cnt));
  endtask

  task automatic send(input logic [W-1:0] w, output int unsigned n);
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    do begin
      step();
      n++;
    end while (!m_acc && n < 40);
    if (!m_acc) begin
      n_checks++;
      $display("FAIL accept_timeout: no accept after %0d cycles", n);
    end
    in_valid = 1'b0;
    in_data  = W'($urandom);
  endtask

  task automatic send_frame(input logic [W-1:0] w);
    int unsigned n;
    send(w, n);
    repeat (PRE + W + G) step();
  endtask

  initial begin
    int unsigned n;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; obs_v = '0;
    step(); step();
    reset = 1'b0;
    repeat (10) step();

    send_frame(8'hA5);
    check("a5_stream", 32'(obs_v[13:0]), 32'(14'b1010_10100101_00));
    check("a5_count", 32'(dframe_cnt), 32'd1);
    check("a5_ready", 32'(din_ready), 32'd1);

    // Held valid: second word waits for the gap to finish, then follows immediately.
    in_valid = 1'b1; in_data = 8'h00;
    step();
    in_data = 8'hFF;
    repeat (PRE + W + G + 1) step();
    in_valid = 1'b0;
    repeat (PRE + W + G) step();
    check("b2b_stream", obs_v[28:0], 32'(29'b1010_00000000_00_0_1010_11111111_00));
    check("b2b_count", 32'(dframe_cnt), 32'd3);

    send(8'h96, n);
    send(8'h3C, n);
    check("busy_wait", n, 32'(PRE + W + G + 1));
    repeat (PRE + W + G) step();
    check("busy_count", 32'(dframe_cnt), 32'd5);

    send(8'h5A, n);
    repeat (PRE + 3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_out", 32'(dout), 32'd0);
    check("rst_busy", 32'(dbusy), 32'd0);
    check("rst_ready", 32'(din_ready), 32'd1);
    check("rst_count", 32'(dframe_cnt), 32'd0);
    repeat (3) step();

    for (int i = 0; i < 17; i++) send_frame(W'($urandom));
    check("wrap_count", 32'(dframe_cnt), 32'd1);

    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) == 0);
      in_data  = W'($urandom);
      reset    = ($urandom_range(0, 149) == 0);
      step();
    end
    reset = 1'b0; in_valid = 1'b0;
    repeat (20) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
